// File: rtl/microwave_ctrl_if.sv
// Panel/display bundle between the oven front-panel logic and microwave_ctrl.
// Latency: none (wires only); the controller registers everything it drives.
// Backpressure: none; these are level/pulse controls sampled every clk cycle.
//
// Signals:
//   door      1 = door open (level)
//   start     start/resume request
//   cancel    abort request
//   load      latch time_in/power_in
//   time_in   cook time in ticks
//   power_in  power level 0..2^PWR_W-1
//   lock      child lock (only when MWAVE_CHILD_LOCK_EN is defined)
//   heat      magnetron enable
//   light     cavity lamp
//   bell      sounder
//   remaining ticks left, for the display
//   state     CLOSED=0, COOK=1, PAUSE=2, OPEN=3, BELL=4
//
// master = panel side (drives requests), slave = controller side.
// TIME_W/PWR_W must match the parameters of the controller it is bound to.
interface microwave_ctrl_if #(
  parameter int TIME_W = 8,
  parameter int PWR_W  = 2
);
  logic              door;
  logic              start;
  logic              cancel;
  logic              load;
  logic [TIME_W-1:0] time_in;
  logic [PWR_W-1:0]  power_in;
`ifdef MWAVE_CHILD_LOCK_EN
  logic              lock;
`endif
  logic              heat;
  logic              light;
  logic              bell;
  logic [TIME_W-1:0] remaining;
  logic [2:0]        state;

`ifdef MWAVE_CHILD_LOCK_EN
  modport master (
    output door, start, cancel, load, time_in, power_in, lock,
    input  heat, light, bell, remaining, state
  );

  modport slave (
    input  door, start, cancel, load, time_in, power_in, lock,
    output heat, light, bell, remaining, state
  );
`else
  modport master (
    output door, start, cancel, load, time_in, power_in,
    input  heat, light, bell, remaining, state
  );

  modport slave (
    input  door, start, cancel, load, time_in, power_in,
    output heat, light, bell, remaining, state
  );
`endif

endinterface

// File: rtl/microwave_ctrl.sv
// Microwave-oven controller: door/cook/pause/bell FSM, countdown timer, duty-cycle power, timed bell.
// Latency: inputs sampled at edge N act on state/outputs visible in cycle N+1; outputs are a Moore decode.
// Backpressure: none; requests not legal in the current state are simply ignored.
//
// Ports:
//   clk   rising-edge clock
//   nrst  asynchronous active-low reset (release synchronous to clk)
//   bus   microwave_ctrl_if.slave: door/start/cancel/load/time_in/power_in[/lock] in,
//         heat/light/bell/remaining/state out
//
// Optional feature: define MWAVE_CHILD_LOCK_EN to add the child-lock input;
// lock=1 then masks start and load in every state (door, cancel and the timer
// keep working, so a cook in progress still completes). Without the macro the
// controller behaves exactly as with lock tied low.
module microwave_ctrl #(
  parameter int TIME_W   = 8,     // cook-time counter width, in ticks
  parameter int TICK_DIV = 1000,  // clk cycles per tick, >= 2
  parameter int PWR_W    = 2,     // power-level width
  parameter int BELL_LEN = 3      // ticks the bell sounds, >= 1
) (
  input  logic             clk,
  input  logic             nrst,
  microwave_ctrl_if.slave  bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BC_W  = (BELL_LEN > 1) ? $clog2(BELL_LEN) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  // bell_cnt counts completed bell ticks; the tick that would bring it to
  // BELL_LEN ends the bell, so it never needs to hold BELL_LEN itself.
  localparam logic [BC_W-1:0]   BELL_LAST = BC_W'(BELL_LEN - 1);
  localparam logic [TIME_W-1:0] TIME_ONE  = TIME_W'(1);

  typedef enum logic [2:0] {
    ST_CLOSED = 3'd0,
    ST_COOK   = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_OPEN   = 3'd3,
    ST_BELL   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] remaining_q, remaining_d;
  logic [PWR_W-1:0]  power_q, power_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [PWR_W-1:0]  phase_q, phase_d;
  logic [BC_W-1:0]   bell_cnt_q, bell_cnt_d;

  logic lock_w;
  logic start_ok;
  logic load_ok;
  logic tick;

`ifdef MWAVE_CHILD_LOCK_EN
  assign lock_w = bus.lock;
`else
  assign lock_w = 1'b0;
`endif

  assign start_ok = bus.start & ~lock_w;
  assign load_ok  = bus.load  & ~lock_w;

  // Only meaningful in COOK/BELL; the prescaler holds its value elsewhere.
  assign tick = (presc_q == PRE_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_CLOSED;
      remaining_q <= '0;
      power_q     <= '1;
      presc_q     <= '0;
      phase_q     <= '0;
      bell_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      power_q     <= power_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      bell_cnt_q  <= bell_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority in every state: door > cancel > tick/start/load.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    power_d     = power_q;
    presc_d     = presc_q;
    bell_cnt_d  = bell_cnt_q;

    case (state_q)
      ST_CLOSED: begin
        if (bus.door) begin
          state_d = ST_OPEN;
        end else if (load_ok) begin
          // Programming takes the cycle; a simultaneous start is dropped.
          remaining_d = bus.time_in;
          power_d     = bus.power_in;
        end else if (start_ok && (remaining_q != '0)) begin
          state_d = ST_COOK;
          presc_d = '0;
        end
      end

      ST_COOK: begin
        if (bus.door) begin
          // The prescaler is not advanced on the door cycle, so on resume the
          // partial tick continues exactly where it stopped.
          state_d = ST_PAUSE;
        end else if (bus.cancel) begin
          state_d     = ST_CLOSED;
          remaining_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (remaining_q <= TIME_ONE) begin
            remaining_d = '0;
            state_d     = ST_BELL;
            bell_cnt_d  = '0;
          end else begin
            remaining_d = remaining_q - TIME_ONE;
          end
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end

      ST_PAUSE: begin
        if (bus.cancel) begin
          state_d     = bus.door ? ST_OPEN : ST_CLOSED;
          remaining_d = '0;
        end else if (!bus.door && start_ok) begin
          // Resume only on an explicit start with the door shut; prescaler kept.
          state_d = ST_COOK;
        end
      end

      ST_OPEN: begin
        if (load_ok) begin
          remaining_d = bus.time_in;
          power_d     = bus.power_in;
        end
        if (!bus.door) begin
          state_d = ST_CLOSED;
        end
      end

      ST_BELL: begin
        if (bus.door) begin
          state_d = ST_OPEN;
        end else if (bus.cancel) begin
          state_d = ST_CLOSED;
        end else if (tick) begin
          presc_d = '0;
          if (bell_cnt_q == BELL_LAST) begin
            state_d = ST_CLOSED;
          end else begin
            bell_cnt_d = bell_cnt_q + BC_W'(1);
          end
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end

      default: begin
        state_d     = ST_CLOSED;
        remaining_d = '0;
        presc_d     = '0;
        bell_cnt_d  = '0;
      end
    endcase
  end

  // Duty-cycle phase: counts cycles of uninterrupted cooking and restarts from
  // 0 on every COOK entry, so the on-window always leads the period.
  always_comb begin
    phase_d = '0;
    if ((state_q == ST_COOK) && (state_d == ST_COOK)) begin
      phase_d = phase_q + PWR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs from registered state only (reset clears them immediately).
  // Level p heats while phase <= p: p+1 of every 2^PWR_W cycles, max = always on.
  // ---------------------------------------------------------------------------
  assign bus.heat      = (state_q == ST_COOK) && (phase_q <= power_q);
  assign bus.light     = (state_q == ST_COOK) || (state_q == ST_PAUSE) || (state_q == ST_OPEN);
  assign bus.bell      = (state_q == ST_BELL);
  assign bus.remaining = remaining_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: directed scenarios with literal
// expectations, then randomized panel activity compared every cycle against a
// cycle-budget reference model (cook time tracked as cycles left, not ticks).
module tb_microwave_ctrl;

  localparam int TIME_W   = 8;
  localparam int TICK_DIV = 4;
  localparam int PWR_W    = 2;
  localparam int BELL_LEN = 2;
  localparam int PERIOD   = 1 << PWR_W;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  always #5 clk = ~clk;

  microwave_ctrl_if #(.TIME_W(TIME_W), .PWR_W(PWR_W)) bus ();

  microwave_ctrl #(
    .TIME_W  (TIME_W),
    .TICK_DIV(TICK_DIV),
    .PWR_W   (PWR_W),
    .BELL_LEN(BELL_LEN)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Modes: 0 closed, 1 cook, 2 pause, 3 open, 4 bell.
  // While cooking the model keeps the number of cook cycles still owed;
  // the displayed tick count is that budget rounded up to whole ticks.
  // ---------------------------------------------------------------------------
  int m_mode, m_time, m_pwr, m_left, m_run, m_bell;

  function automatic bit lock_in();
`ifdef MWAVE_CHILD_LOCK_EN
    return bus.lock;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_mode = 0; m_time = 0; m_pwr = PERIOD - 1;
    m_left = 0; m_run = 0;  m_bell = 0;
  endtask

  task automatic m_step();
    bit st, ld;
    st = bus.start && !lock_in();
    ld = bus.load  && !lock_in();
    case (m_mode)
      0: if (bus.door) m_mode = 3;
         else if (ld) begin m_time = int'(bus.time_in); m_pwr = int'(bus.power_in); end
         else if (st && m_time != 0) begin m_mode = 1; m_left = m_time * TICK_DIV; m_run = 0; end
      1: if (bus.door) m_mode = 2;
         else if (bus.cancel) begin m_mode = 0; m_time = 0; end
         else begin
           m_left--; m_run++;
           if (m_left == 0) begin m_mode = 4; m_time = 0; m_bell = BELL_LEN * TICK_DIV; end
         end
      2: if (bus.cancel) begin m_mode = bus.door ? 3 : 0; m_time = 0; end
         else if (!bus.door && st) begin m_mode = 1; m_run = 0; end
      3: begin
           if (ld) begin m_time = int'(bus.time_in); m_pwr = int'(bus.power_in); end
           if (!bus.door) m_mode = 0;
         end
      default: if (bus.door) m_mode = 3;
         else if (bus.cancel) m_mode = 0;
         else begin m_bell--; if (m_bell == 0) m_mode = 0; end
    endcase
  endtask

  initial m_reset();

  always @(posedge clk) begin
    if (!nrst) m_reset();
    else m_step();
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && nrst) begin
      check("mdl_state", int'(bus.state), m_mode);
      check("mdl_heat",  int'(bus.heat),  (m_mode == 1 && (m_run % PERIOD) <= m_pwr) ? 1 : 0);
      check("mdl_light", int'(bus.light), (m_mode >= 1 && m_mode <= 3) ? 1 : 0);
      check("mdl_bell",  int'(bus.bell),  (m_mode == 4) ? 1 : 0);
      check("mdl_rem",   int'(bus.remaining),
            (m_mode == 1 || m_mode == 2) ? (m_left + TICK_DIV - 1) / TICK_DIV : m_time);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: all start and end on a falling edge.
  // ---------------------------------------------------------------------------
  task automatic pulse_load(input int t, input int p);
    bus.load = 1'b1; bus.time_in = TIME_W'(t); bus.power_in = PWR_W'(p);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_cancel();
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
  endtask

  initial begin
    int hn, ln, bn, n;
    logic [7:0] pat;

    bus.door = 1'b0; bus.start = 1'b0; bus.cancel = 1'b0; bus.load = 1'b0;
    bus.time_in = '0; bus.power_in = '0;
`ifdef MWAVE_CHILD_LOCK_EN
    bus.lock = 1'b0;
`endif

    // Reset state
    @(negedge clk);
    check("rst_state", int'(bus.state), 0);
    check("rst_rem",   int'(bus.remaining), 0);
    check("rst_outs",  int'({bus.heat, bus.light, bus.bell}), 0);
    @(negedge clk);
    nrst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Full cook at max power, then the bell
    pulse_load(3, 3);
    pulse_start();
    hn = 0; ln = 0; bn = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 0)  check("s1_rem_t0",  int'(bus.remaining), 3);
      if (i == 4)  check("s1_rem_t4",  int'(bus.remaining), 2);
      if (i == 8)  check("s1_rem_t8",  int'(bus.remaining), 1);
      if (i == 12) check("s1_rem_t12", int'(bus.remaining), 0);
      if (i == 12) check("s1_bell_st", int'(bus.state), 4);
      if (i == 20) check("s1_done_st", int'(bus.state), 0);
      hn += int'(bus.heat); ln += int'(bus.light); bn += int'(bus.bell);
      @(negedge clk);
    end
    check("s1_heat_cycles",  hn, 12);
    check("s1_light_cycles", ln, 12);
    check("s1_bell_cycles",  bn, 8);

    // Power 1 duty pattern, then cancel
    pulse_load(4, 1);
    pulse_start();
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      pat = {pat[6:0], bus.heat};
      @(negedge clk);
    end
    check("s2_heat_pattern", int'(pat), 8'b1100_1100);
    check("s2_rem_before_cancel", int'(bus.remaining), 2);
    pulse_cancel();
    check("s2_cancel_state", int'(bus.state), 0);
    check("s2_cancel_rem",   int'(bus.remaining), 0);

    // Door mid-tick pauses, closing door does not resume, start does
    pulse_load(5, 3);
    pulse_start();
    repeat (13) @(negedge clk);
    check("s3_rem_before_door", int'(bus.remaining), 2);
    bus.door = 1'b1;
    @(negedge clk);
    check("s3_pause_state", int'(bus.state), 2);
    check("s3_pause_heat",  int'(bus.heat), 0);
    check("s3_pause_light", int'(bus.light), 1);
    check("s3_pause_rem",   int'(bus.remaining), 2);
    bus.door = 1'b0;
    repeat (3) @(negedge clk);
    check("s3_closed_still_pause", int'(bus.state), 2);
    check("s3_closed_rem",         int'(bus.remaining), 2);
    pulse_start();
    n = 0;
    while (bus.state != 3'd4 && n < 50) begin @(negedge clk); n++; end
    check("s3_resume_to_bell", n, 7);
    n = 0;
    while (bus.state != 3'd0 && n < 50) begin @(negedge clk); n++; end
    check("s3_bell_len", n, 8);

    // Start with nothing loaded; programming with the door open
    pulse_start();
    check("s4_start_zero", int'(bus.state), 0);
    bus.door = 1'b1;
    @(negedge clk);
    check("s4_open_state", int'(bus.state), 3);
    check("s4_open_light", int'(bus.light), 1);
    pulse_load(7, 2);
    check("s4_open_load", int'(bus.remaining), 7);
    bus.door = 1'b0;
    @(negedge clk);
    check("s4_closed_state", int'(bus.state), 0);
    check("s4_closed_rem",   int'(bus.remaining), 7);

    // Door beats cancel in COOK; cancel in PAUSE with door open -> OPEN
    pulse_start();
    check("s5_cook", int'(bus.state), 1);
    repeat (2) @(negedge clk);
    bus.door = 1'b1; bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("s5_door_wins", int'(bus.state), 2);
    check("s5_door_wins_rem", int'(bus.remaining), 7);
    pulse_cancel();
    check("s5_cancel_open", int'(bus.state), 3);
    check("s5_cancel_rem",  int'(bus.remaining), 0);
    bus.door = 1'b0;
    @(negedge clk);
    check("s5_closed", int'(bus.state), 0);

    // Asynchronous reset mid-cook
    pulse_load(9, 3);
    pulse_start();
    repeat (3) @(negedge clk);
    check("s6_heat_before_rst", int'(bus.heat), 1);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check("s6_rst_heat",  int'(bus.heat), 0);
    check("s6_rst_light", int'(bus.light), 0);
    check("s6_rst_bell",  int'(bus.bell), 0);
    check("s6_rst_rem",   int'(bus.remaining), 0);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("s6_after_rst", int'(bus.state), 0);

`ifdef MWAVE_CHILD_LOCK_EN
    // Child lock masks load/start but not a cook in progress
    bus.lock = 1'b1;
    pulse_load(5, 3);
    check("lk_load_ignored", int'(bus.remaining), 0);
    bus.lock = 1'b0;
    pulse_load(2, 3);
    bus.lock = 1'b1;
    pulse_start();
    check("lk_start_ignored", int'(bus.state), 0);
    bus.lock = 1'b0;
    pulse_start();
    bus.lock = 1'b1;
    n = 0;
    while (bus.state != 3'd4 && n < 50) begin @(negedge clk); n++; end
    check("lk_cook_completes", n, 8);
    n = 0;
    while (bus.state != 3'd0 && n < 50) begin @(negedge clk); n++; end
    check("lk_bell_len", n, 8);
    bus.lock = 1'b0;
`endif

    // Randomized panel activity, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.door = ~bus.door;
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.cancel   = ($urandom_range(0, 59) == 0);
      bus.load     = ($urandom_range(0, 11) == 0);
      bus.time_in  = TIME_W'($urandom_range(0, 6));
      bus.power_in = PWR_W'($urandom_range(0, PERIOD - 1));
`ifdef MWAVE_CHILD_LOCK_EN
      if ($urandom_range(0, 29) == 0) bus.lock = ~bus.lock;
`endif
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
